// File: rtl/ysyx_axi4_sram_slave.sv
// ysyx_axi4_sram_slave
// AXI4 responder in front of an on-chip SRAM of 64-bit words. It takes the
// place of the external SoC memory when the NPC core is built standalone.
// The read and write channels have independent FSMs. Bursts can be FIXED or
// INCR with up to 256 beats. Writes are byte-strobed. The read latency is
// programmable. An optional LFSR randomly withholds AR/AW ready so the
// master sees back-pressure.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ar* / arready_o               read address channel
//   rid_o rdata_o rresp_o rlast_o rvalid_o / rready   read data channel
//   aw* / awready_o               write address channel
//   wdata wstrb wlast wvalid / wready_o               write data channel
//   bid_o bresp_o bvalid_o / bready                   write response channel
module ysyx_axi4_sram_slave #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 64,
  parameter int              DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE     = 32'h8000_0000,
  parameter int              RD_LAT     = 1,
  parameter int              RAND_EN    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          arburst,
  input  logic [2:0]          arsize,
  input  logic [7:0]          arlen,
  input  logic [3:0]          arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready_o,
  output logic [3:0]          rid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rlast_o,
  output logic                rvalid_o,
  input  logic                rready,
  input  logic [1:0]          awburst,
  input  logic [2:0]          awsize,
  input  logic [7:0]          awlen,
  input  logic [3:0]          awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready_o,
  output logic [3:0]          bid_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready
);

  localparam int               DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W:0]  SPAN   = (ADDR_W+1)'(1) << (DEPTH_LOG2 + 3);
  localparam logic [3:0]       LAT_M1 = 4'(RD_LAT - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return DEPTH_LOG2'((a - BASE) >> 3);
  endfunction

  // Response for one beat. Unsupported bursts (WRAP and the reserved
  // encoding) and sizes above 8 bytes win over the range check.
  function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] a,
                                           input logic [1:0] burst,
                                           input logic [2:0] size);
    if (burst[1] || size > 3'd3) return RESP_SLVERR;
    if ({1'b0, a - BASE} >= SPAN) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] burst,
                                                  input logic [2:0] size);
    return (burst == 2'b01) ? a + (ADDR_W'(1) << size) : a;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // Back-pressure generator
  logic [19:0] lfsr;
  logic        gate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 20'd1;
    else     lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[18]};
  end

  assign gate = (RAND_EN != 0) ? lfsr[19] : 1'b1;

  // Read channel
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
  rstate_t           rstate;
  logic [ADDR_W-1:0] raddr;
  logic [7:0]        rlen, rcnt;
  logic [2:0]        rsize;
  logic [1:0]        rburst;
  logic [3:0]        rwait;
  logic              ar_ok;
  logic [ADDR_W-1:0] rsel_addr;
  logic [2:0]        rsel_size;
  logic [1:0]        rsel_burst, rsel_resp;
  logic [DATA_W-1:0] rsel_data;

  // Handshake qualifier kept free of rst so the flops see rst only as
  // their asynchronous reset; the port adds the rst gating.
  assign ar_ok     = (rstate == R_IDLE) && gate;
  assign arready_o = !rst && ar_ok;

  // Address of the beat that is about to be registered onto R: the request
  // itself when latency is zero, the captured address after the wait, or the
  // stepped address once a beat has been accepted.
  always_comb begin
    rsel_addr  = raddr;
    rsel_size  = rsize;
    rsel_burst = rburst;
    if (rstate == R_IDLE) begin
      rsel_addr  = araddr;
      rsel_size  = arsize;
      rsel_burst = arburst;
    end else if (rstate == R_DATA) begin
      rsel_addr = step_addr(raddr, rburst, rsize);
    end
  end

  assign rsel_resp = beat_resp(rsel_addr, rsel_burst, rsel_size);
  assign rsel_data = (rsel_resp == RESP_OKAY) ? mem[word_idx(rsel_addr)] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate   <= R_IDLE;
      raddr    <= '0;
      rlen     <= '0;
      rcnt     <= '0;
      rsize    <= '0;
      rburst   <= '0;
      rwait    <= '0;
      rid_o    <= '0;
      rdata_o  <= '0;
      rresp_o  <= '0;
      rlast_o  <= 1'b0;
      rvalid_o <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arvalid && ar_ok) begin
            raddr  <= araddr;
            rlen   <= arlen;
            rsize  <= arsize;
            rburst <= arburst;
            rid_o  <= arid;
            rcnt   <= '0;
            if (RD_LAT == 0) begin
              rstate   <= R_DATA;
              rdata_o  <= rsel_data;
              rresp_o  <= rsel_resp;
              rlast_o  <= (arlen == 8'd0);
              rvalid_o <= 1'b1;
            end else begin
              rstate <= R_WAIT;
              rwait  <= LAT_M1;
            end
          end
        end
        R_WAIT: begin
          if (rwait == 4'd0) begin
            rstate   <= R_DATA;
            rdata_o  <= rsel_data;
            rresp_o  <= rsel_resp;
            rlast_o  <= (rlen == 8'd0);
            rvalid_o <= 1'b1;
          end else begin
            rwait <= rwait - 4'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rcnt == rlen) begin
              rstate   <= R_IDLE;
              rvalid_o <= 1'b0;
              rlast_o  <= 1'b0;
            end else begin
              rcnt    <= rcnt + 8'd1;
              raddr   <= rsel_addr;
              rdata_o <= rsel_data;
              rresp_o <= rsel_resp;
              rlast_o <= (rcnt + 8'd1 == rlen);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write channel
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  wstate_t           wstate;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wlen, wcnt;
  logic [2:0]        wsize;
  logic [1:0]        wburst;
  logic              w_dec;
  logic              aw_ok, w_hs, w_cnt_end, w_slv;
  logic [1:0]        wbeat_resp;

  assign aw_ok      = (wstate == W_IDLE) && gate;
  assign awready_o  = !rst && aw_ok;
  assign wready_o   = (wstate == W_DATA);
  assign w_hs       = wvalid && (wstate == W_DATA);
  assign wbeat_resp = beat_resp(waddr, wburst, wsize);
  assign w_cnt_end  = (wcnt == wlen);
  // wlast must coincide with the beat count reaching awlen
  assign w_slv      = (wbeat_resp == RESP_SLVERR) || (wlast != w_cnt_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate   <= W_IDLE;
      waddr    <= '0;
      wlen     <= '0;
      wcnt     <= '0;
      wsize    <= '0;
      wburst   <= '0;
      w_dec    <= 1'b0;
      bid_o    <= '0;
      bresp_o  <= '0;
      bvalid_o <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (awvalid && aw_ok) begin
            waddr  <= awaddr;
            wlen   <= awlen;
            wsize  <= awsize;
            wburst <= awburst;
            bid_o  <= awid;
            wcnt   <= '0;
            w_dec  <= 1'b0;
            wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (wlast || w_cnt_end) begin
              wstate   <= W_RESP;
              bvalid_o <= 1'b1;
              if (w_slv)
                bresp_o <= RESP_SLVERR;
              else if (w_dec || wbeat_resp == RESP_DECERR)
                bresp_o <= RESP_DECERR;
              else
                bresp_o <= RESP_OKAY;
            end else begin
              wcnt  <= wcnt + 8'd1;
              waddr <= step_addr(waddr, wburst, wsize);
              w_dec <= w_dec || (wbeat_resp == RESP_DECERR);
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_o <= 1'b0;
            wstate   <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // SRAM array: no reset, contents survive rst
  always_ff @(posedge clk) begin
    if (w_hs && wbeat_resp == RESP_OKAY) begin
      for (int i = 0; i < DATA_W/8; i++)
        if (wstrb[i]) mem[word_idx(waddr)][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ysyx_axi4_sram_slave.sv
// Testbench for ysyx_axi4_sram_slave. Directed protocol steps come first,
// then randomized transactions. Expectations come from a byte-addressed
// reference memory and per-beat response rules.
module tb_ysyx_axi4_sram_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  arburst, awburst;
  logic [2:0]  arsize, awsize;
  logic [7:0]  arlen, awlen;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        arready_o, rlast_o, rvalid_o, awready_o, wready_o, bvalid_o;
  logic [3:0]  rid_o, bid_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o, bresp_o;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem_b [int unsigned];
  logic [63:0] wd_a [256];
  logic [7:0]  ws_a [256];

  ysyx_axi4_sram_slave #(
    .ADDR_W(32), .DATA_W(64), .DEPTH_LOG2(12), .BASE(BASE),
    .RD_LAT(1), .RAND_EN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .arburst(arburst), .arsize(arsize), .arlen(arlen), .arid(arid),
    .araddr(araddr), .arvalid(arvalid), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready(rready),
    .awburst(awburst), .awsize(awsize), .awlen(awlen), .awid(awid),
    .awaddr(awaddr), .awvalid(awvalid), .awready_o(awready_o),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules
  function automatic logic [1:0] m_resp(input logic [31:0] a, input logic [1:0] b,
                                        input logic [2:0] s);
    if (b == 2'b10 || b == 2'b11 || s > 3'd3) return 2'b10;
    if (a < BASE || a >= BASE + SPAN) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a, input logic [1:0] b,
                                         input logic [2:0] s);
    if (b == 2'b01) return a + (32'd1 << s);
    return a;
  endfunction

  function automatic logic [63:0] m_word(input logic [31:0] a);
    logic [63:0] w;
    int unsigned o;
    w = '0;
    o = (a - BASE) & ~32'd7;
    for (int i = 0; i < 8; i++)
      if (mem_b.exists(o + i)) w[8*i +: 8] = mem_b[o + i];
    return w;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] st);
    int unsigned o;
    o = (a - BASE) & ~32'd7;
    for (int i = 0; i < 8; i++)
      if (st[i]) mem_b[o + i] = d[8*i +: 8];
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id);
    int n;
    bit done;
    n = 0;
    done = 0;
    araddr = a; arlen = len; arsize = s; arburst = b; arid = id; arvalid = 1'b1;
    while (!done && n < 200) begin
      if (arready_o) done = 1;
      tick();
      n++;
    end
    arvalid = 1'b0;
    chk("ar_handshake", 64'(done), 64'd1);
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id);
    int n;
    bit done;
    n = 0;
    done = 0;
    awaddr = a; awlen = len; awsize = s; awburst = b; awid = id; awvalid = 1'b1;
    while (!done && n < 200) begin
      if (awready_o) done = 1;
      tick();
      n++;
    end
    awvalid = 1'b0;
    chk("aw_handshake", 64'(done), 64'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id,
                         input int hold_beat, input int hold_n, input bit rnd);
    logic [63:0] ed [256];
    logic [1:0]  er [256];
    logic [31:0] x;
    int h;
    x = a;
    for (int i = 0; i <= int'(len); i++) begin
      er[i] = m_resp(x, b, s);
      ed[i] = (er[i] == 2'b00) ? m_word(x) : 64'd0;
      x = m_next(x, b, s);
    end
    rready = 1'b0;
    ar_send(a, len, s, b, id);
    chk("r_lat_low", 64'(rvalid_o), 64'd0);
    tick();
    for (int i = 0; i <= int'(len); i++) begin
      h = (i == hold_beat) ? hold_n : 0;
      if (rnd && $urandom_range(0, 3) == 0) h = $urandom_range(1, 2);
      for (int j = 0; j < h; j++) begin
        chk("r_hold_valid", 64'(rvalid_o), 64'd1);
        chk("r_hold_data", rdata_o, ed[i]);
        tick();
      end
      rready = 1'b1;
      chk("r_valid", 64'(rvalid_o), 64'd1);
      chk("r_data", rdata_o, ed[i]);
      chk("r_resp", 64'(rresp_o), 64'(er[i]));
      chk("r_last", 64'(rlast_o), 64'(i == int'(len)));
      chk("r_id", 64'(rid_o), 64'(id));
      tick();
      rready = 1'b0;
    end
    chk("r_done", 64'(rvalid_o), 64'd0);
  endtask

  // Sends nsent beats from wd_a/ws_a with wlast on the final one sent.
  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] s,
                          input logic [1:0] b, input logic [3:0] id,
                          input int nsent, input bit rnd);
    logic [31:0] x;
    logic [1:0]  r, eb;
    bit dec, slv;
    int n, g, d;
    x = a;
    dec = 0;
    slv = (b[1] || s > 3'd3) || (nsent - 1 != int'(len));
    for (int i = 0; i < nsent; i++) begin
      r = m_resp(x, b, s);
      if (r == 2'b11) dec = 1;
      if (r == 2'b00) m_store(x, wd_a[i], ws_a[i]);
      x = m_next(x, b, s);
    end
    eb = slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
    // First beat is already offered while AW is pending; it must not be taken.
    wvalid = 1'b1; wdata = wd_a[0]; wstrb = ws_a[0]; wlast = (nsent == 1);
    chk("w_ready_idle", 64'(wready_o), 64'd0);
    aw_send(a, len, s, b, id);
    chk("w_ready_after_aw", 64'(wready_o), 64'd1);
    for (int i = 0; i < nsent; i++) begin
      if (i > 0) begin
        g = (rnd && $urandom_range(0, 3) == 0) ? 1 : 0;
        wvalid = 1'b0;
        repeat (g) tick();
        wvalid = 1'b1; wdata = wd_a[i]; wstrb = ws_a[i]; wlast = (i == nsent - 1);
      end
      n = 0;
      while (!wready_o && n < 50) begin
        tick();
        n++;
      end
      chk("w_ready", 64'(wready_o), 64'd1);
      tick();
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    chk("b_valid", 64'(bvalid_o), 64'd1);
    chk("b_resp", 64'(bresp_o), 64'(eb));
    chk("b_id", 64'(bid_o), 64'(id));
    d = rnd ? $urandom_range(0, 2) : 1;
    for (int j = 0; j < d; j++) begin
      chk("b_hold", 64'(bvalid_o), 64'd1);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_done", 64'(bvalid_o), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    int kind;

    rst = 1'b1;
    arburst = '0; arsize = '0; arlen = '0; arid = '0; araddr = '0; arvalid = 1'b0;
    awburst = '0; awsize = '0; awlen = '0; awid = '0; awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_arready", 64'(arready_o), 64'd0);
    chk("rst_awready", 64'(awready_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_wready", 64'(wready_o), 64'd0);
    chk("rst_bvalid", 64'(bvalid_o), 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_rresp", 64'(rresp_o), 64'd0);
    chk("rst_rlast", 64'(rlast_o), 64'd0);
    chk("rst_bresp", 64'(bresp_o), 64'd0);
    chk("rst_rid", 64'(rid_o), 64'd0);
    chk("rst_bid", 64'(bid_o), 64'd0);
    rst = 1'b0;

    // Fill the first 128 words so every later in-range read has known data
    for (int i = 0; i < 128; i++) begin
      wd_a[i] = {$urandom, $urandom};
      ws_a[i] = 8'hFF;
    end
    do_write(BASE, 8'd127, 3'd3, 2'b01, 4'h0, 128, 1'b0);

    // Single write and read-back
    wd_a[0] = 64'h1122_3344_5566_7788; ws_a[0] = 8'hFF;
    do_write(32'h8000_0008, 8'd0, 3'd3, 2'b01, 4'h3, 1, 1'b0);
    do_read(32'h8000_0008, 8'd0, 3'd3, 2'b01, 4'h6, -1, 0, 1'b0);

    // Byte strobe: one lane overwritten
    wd_a[0] = 64'h0000_00AA_0000_0000; ws_a[0] = 8'h10;
    do_write(32'h8000_0008, 8'd0, 3'd3, 2'b01, 4'h4, 1, 1'b0);
    do_read(32'h8000_0008, 8'd0, 3'd3, 2'b01, 4'h7, -1, 0, 1'b0);

    // INCR burst, rready held low for two cycles on beat 1
    for (int i = 0; i < 4; i++) begin
      wd_a[i] = 64'(i);
      ws_a[i] = 8'hFF;
    end
    do_write(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'h9, 4, 1'b0);
    do_read(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'hA, 1, 2, 1'b0);

    // Error responses
    do_read(32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'h1, -1, 0, 1'b0);
    do_read(32'h8000_0100, 8'd3, 3'd3, 2'b10, 4'h2, -1, 0, 1'b0);
    wd_a[0] = 64'hDEAD_BEEF_0000_0001; ws_a[0] = 8'hFF;
    do_write(BASE + SPAN, 8'd0, 3'd3, 2'b01, 4'h5, 1, 1'b0);
    wd_a[0] = 64'hA5A5_0000_0000_0001; wd_a[1] = 64'hA5A5_0000_0000_0002;
    ws_a[0] = 8'hFF; ws_a[1] = 8'h0F;
    do_write(32'h8000_0140, 8'd3, 3'd3, 2'b01, 4'hB, 2, 1'b0);
    do_read(32'h8000_0140, 8'd1, 3'd3, 2'b01, 4'hC, -1, 0, 1'b0);

    // Concurrent read burst and write to a different word
    wd_a[0] = 64'h0F0E_0D0C_0B0A_0908; ws_a[0] = 8'hFF;
    fork
      do_read(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'hD, -1, 0, 1'b0);
      do_write(32'h8000_0200, 8'd0, 3'd3, 2'b01, 4'hE, 1, 1'b0);
    join
    do_read(32'h8000_0200, 8'd0, 3'd3, 2'b01, 4'hF, -1, 0, 1'b0);

    // Reset in the middle of a read burst
    rready = 1'b0;
    ar_send(32'h8000_0100, 8'd3, 3'd3, 2'b01, 4'h8);
    tick();
    chk("mid_rvalid_beat0", 64'(rvalid_o), 64'd1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("mid_rvalid_beat1", 64'(rvalid_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("mid_rst_rdata", rdata_o, 64'd0);
    chk("mid_rst_arready", 64'(arready_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_read(32'h8000_0108, 8'd1, 3'd3, 2'b01, 4'h2, -1, 0, 1'b0);

    // Randomized traffic under LFSR back-pressure
    for (int t = 0; t < 1000; t++) begin
      kind = $urandom_range(0, 19);
      rb = 2'($urandom_range(0, 1));
      rs = 3'($urandom_range(0, 3));
      rl = 8'($urandom_range(0, 7));
      ra = BASE + $urandom_range(0, 32'h2FF);
      if (kind == 0) ra = ($urandom_range(0, 1) == 0) ? BASE - 32'(8 * $urandom_range(1, 16))
                                                      : BASE + SPAN + $urandom_range(0, 255);
      else if (kind == 1) rb = 2'b10;
      else if (kind == 2) begin rb = 2'b01; rs = 3'($urandom_range(4, 7)); end
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= int'(rl); i++) begin
          wd_a[i] = {$urandom, $urandom};
          ws_a[i] = 8'($urandom_range(0, 255));
        end
        do_write(ra, rl, rs, rb, 4'($urandom_range(0, 15)), int'(rl) + 1, 1'b1);
      end else begin
        do_read(ra, rl, rs, rb, 4'($urandom_range(0, 15)), -1, 0, 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
